// File: rtl/tap_player.sv
// tap_player: captures a .TAP image from the HPS ioctl download stream into an
// internal byte buffer and replays it as the Oric cassette waveform.
//
// Ports
//   clk_sys         system clock
//   reset           synchronous, active-high reset
//   ioctl_download  download window active
//   ioctl_index     download target selector (TAP_INDEX selects the tape)
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address within the file
//   ioctl_dout      byte data
//   play            level: 1 = run, 0 = pause (sampled between bytes only)
//   rewind          one-cycle pulse, read pointer back to 0
//   tape_out        cassette signal to K7_TAPEIN, idles high
//   busy            a byte frame is being serialised
//   eof             read pointer has reached the image length
//   tape_len        captured image length in bytes
//
// Frame per byte: start 0, D0..D7, odd parity, four stop 1s.
// Bit cell: high T, then low T (bit 1) or low 2T (bit 0).
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for play with bytes left; tape_out held high
// S_FETCH | buffer read at rd_ptr in flight
// S_LATCH | read data framed into the 14-bit shift register
// S_HI    | high half of the current bit cell (T cycles)
// S_LO    | low half of the current bit cell (T or 2T cycles)

module tap_player #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned T_CYCLES  = 4992,
  parameter logic [7:0]  TAP_INDEX = 8'd1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              play,
  input  logic              rewind,
  output logic              tape_out,
  output logic              busy,
  output logic              eof,
  output logic [ADDR_W:0]   tape_len
);

  localparam int unsigned CNT_W = $clog2(2 * T_CYCLES);
  localparam int unsigned CAP_N = 1 << ADDR_W;
  localparam logic [ADDR_W:0]  CAP   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] T_M1  = CNT_W'(T_CYCLES - 1);
  localparam logic [CNT_W-1:0] T2_M1 = CNT_W'(2 * T_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_HI, S_LO} state_t;

  state_t           state;
  logic [7:0]       mem [CAP_N];
  logic [7:0]       rd_data;
  logic [ADDR_W:0]  rd_ptr;
  logic [ADDR_W:0]  run_max;
  logic [13:0]      shreg;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] cnt;
  logic             dl_q;
  logic             rew_pend;

  logic             downloading;
  logic             dl_fall;
  logic             addr_in_range;
  logic [ADDR_W:0]  wr_len;

  assign downloading   = ioctl_download && (ioctl_index == TAP_INDEX);
  assign dl_fall       = dl_q && !downloading;
  assign addr_in_range = (ioctl_addr >> ADDR_W) == 25'd0;
  // Length implied by this write, saturating at the buffer capacity.
  assign wr_len        = addr_in_range ? ({1'b0, ioctl_addr[ADDR_W-1:0]} + ONE) : CAP;

  assign busy = (state != S_IDLE);
  assign eof  = (rd_ptr == tape_len) && !busy;

  // Buffer is left uninitialised across reset on purpose: an image survives a
  // core reset and can be replayed after rewinding.
  always_ff @(posedge clk_sys) begin
    if (downloading && ioctl_wr && addr_in_range)
      mem[ioctl_addr[ADDR_W-1:0]] <= ioctl_dout;
    if (state == S_FETCH)
      rd_data <= mem[rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= S_IDLE;
      tape_out <= 1'b1;
      rd_ptr   <= '0;
      tape_len <= '0;
      run_max  <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      dl_q     <= 1'b0;
      rew_pend <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (downloading && ioctl_wr && (wr_len > run_max))
        run_max <= wr_len;
      if (busy && rewind)
        rew_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          tape_out <= 1'b1;
          // Rewind wins over starting so the next byte fetched is byte 0.
          if (rewind)
            rd_ptr <= '0;
          else if (play && (rd_ptr < tape_len) && !downloading && !dl_fall)
            state <= S_FETCH;
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          shreg    <= {4'b1111, ~^rd_data, rd_data, 1'b0};
          bit_idx  <= '0;
          cnt      <= T_M1;
          tape_out <= 1'b1;
          state    <= S_HI;
        end
        S_HI: begin
          if (cnt == '0) begin
            tape_out <= 1'b0;
            cnt      <= shreg[0] ? T_M1 : T2_M1;
            state    <= S_LO;
          end else begin
            cnt <= cnt - CNT_1;
          end
        end
        S_LO: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_1;
          end else if (bit_idx < 4'd13) begin
            shreg    <= shreg >> 1;
            bit_idx  <= bit_idx + 4'd1;
            cnt      <= T_M1;
            tape_out <= 1'b1;
            state    <= S_HI;
          end else begin
            rd_ptr   <= (rew_pend || rewind) ? '0 : rd_ptr + ONE;
            rew_pend <= 1'b0;
            tape_out <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: begin
          tape_out <= 1'b1;
          state    <= S_IDLE;
        end
      endcase

      // A new tape download aborts playback mid-frame.
      if (downloading && (state != S_IDLE)) begin
        state    <= S_IDLE;
        tape_out <= 1'b1;
      end

      if (dl_fall) begin
        tape_len <= run_max;
        rd_ptr   <= '0;
        run_max  <= '0;
        rew_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tap_player.sv
// Bench for tap_player: random/directed stimulus, expected frames pushed into a
// scoreboard queue, a waveform-decoding monitor pops and compares.
module tb_tap_player;

  localparam int AW = 4;
  localparam int T  = 4;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        play = 1'b0;
  logic        rewind = 1'b0;
  logic        tape_out;
  logic        busy;
  logic        eof;
  logic [AW:0] tape_len;

  tap_player #(.ADDR_W(AW), .T_CYCLES(T), .TAP_INDEX(8'd1)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .play(play), .rewind(rewind),
    .tape_out(tape_out), .busy(busy), .eof(eof), .tape_len(tape_len)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [7:0] d; int gap; } exp_t;
  exp_t sb[$];

  logic [7:0] model_mem [16];
  int model_max = 0;
  int model_len = 0;

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input int idx, input int gap);
    exp_t e;
    e.d = model_mem[idx];
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Queue every remaining byte of the image for back-to-back playback.
  task automatic push_run(input int from, input int to);
    for (int i = from; i < to; i++) push(i, (i == from) ? 0 : T + 3);
  endtask

  task automatic dl_open(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic dl_write(input int addr, input logic [7:0] d);
    ioctl_addr = 25'(addr);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    if (ioctl_index == 8'd1) begin
      if (addr < 16) model_mem[addr] = d;
      if (((addr + 1 < 16) ? addr + 1 : 16) > model_max)
        model_max = (addr + 1 < 16) ? addr + 1 : 16;
    end
    tick();
  endtask

  task automatic dl_close();
    ioctl_download = 1'b0;
    tick();
    if (ioctl_index == 8'd1) begin
      model_len = model_max;
      model_max = 0;
    end
    tick();
  endtask

  task automatic pulse_rewind();
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int max);
    int ok = 0;
    for (int i = 0; i < max; i++) begin
      if (busy == lvl) begin ok = 1; break; end
      tick();
    end
    chk("wait_busy", ok, 1);
  endtask

  task automatic wait_low(input int max);
    int ok = 0;
    for (int i = 0; i < max; i++) begin
      if (!tape_out) begin ok = 1; break; end
      tick();
    end
    chk("wait_tape_low", ok, 1);
  endtask

  task automatic wait_eof(input int max);
    int ok = 0;
    for (int i = 0; i < max; i++) begin
      if (eof) begin ok = 1; break; end
      tick();
    end
    chk("wait_eof", ok, 1);
  endtask

  // Monitor: decodes bit cells from run lengths of tape_out.
  int hi_len = 0, lo_len = 0, nbits = 14, gap = 0, busy_len = 0;
  logic prev_t = 1'b1, prev_b = 1'b0, fbad = 1'b0;
  logic [13:0] fbits = '0;

  function automatic void check_frame();
    exp_t e;
    logic [13:0] ex;
    int dur;
    if (sb.size() == 0) begin
      chk("unexpected_frame", 1, 0);
      return;
    end
    e = sb.pop_front();
    ex[0] = 1'b0;
    ex[8:1] = e.d;
    ex[9] = ($countones(e.d) % 2 == 0);
    ex[13:10] = 4'hF;
    dur = 0;
    for (int i = 0; i < 14; i++) dur += ex[i] ? 2 * T : 3 * T;
    chk("frame_bits", int'(fbits), int'(ex));
    chk("frame_cell_len_bad", int'(fbad), 0);
    chk("frame_busy_cycles", busy_len, dur + 2);
    if (e.gap != 0) chk("frame_gap", gap, e.gap);
  endfunction

  always @(negedge clk_sys) begin
    if (busy && !prev_b) busy_len = 1;
    else if (busy) busy_len++;
    if (tape_out && !prev_t) begin
      if (nbits < 14) begin
        if (lo_len == T) fbits[nbits] = 1'b1;
        else if (lo_len == 2 * T) fbits[nbits] = 1'b0;
        else fbad = 1'b1;
        nbits++;
        if (nbits == 14) check_frame();
      end
      hi_len = 1;
    end else if (tape_out) begin
      hi_len++;
    end else if (prev_t) begin
      if (hi_len != T) begin
        nbits = 0;
        fbad = 1'b0;
        gap = hi_len;
      end
      lo_len = 1;
    end else begin
      lo_len++;
    end
    prev_t = tape_out;
    prev_b = busy;
  end

  initial begin
    int lows, bhi, n;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

    // Reset state and idle with nothing loaded.
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_tape_out", int'(tape_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_eof", int'(eof), 1);
    chk("rst_tape_len", int'(tape_len), 0);
    play = 1'b1;
    lows = 0; bhi = 0;
    repeat (100) begin tick(); if (!tape_out) lows++; if (busy) bhi++; end
    chk("empty_play_lows", lows, 0);
    chk("empty_play_busy", bhi, 0);
    play = 1'b0;

    // Capture three bytes, then a download for another target.
    dl_open(8'd1);
    dl_write(0, 8'h16); dl_write(1, 8'h16); dl_write(2, 8'h24);
    dl_close();
    chk("len_after_dl", int'(tape_len), model_len);
    chk("len_is_3", int'(tape_len), 3);
    chk("eof_after_dl", int'(eof), 0);
    dl_open(8'd2);
    for (int i = 0; i < 5; i++) dl_write(i, 8'hFF);
    dl_close();
    chk("len_other_index", int'(tape_len), 3);

    // Single byte 0x16, then stop.
    push(0, 0);
    play = 1'b1;
    wait_busy(1'b1, 20);
    play = 1'b0;
    wait_busy(1'b0, 400);
    repeat (5) tick();
    chk("one_byte_ptr", int'(dut.rd_ptr), 1);

    // Rewind in idle, then the full image back to back.
    pulse_rewind();
    chk("rewind_idle_ptr", int'(dut.rd_ptr), 0);
    push_run(0, 3);
    play = 1'b1;
    wait_eof(1000);
    chk("eof_busy", int'(busy), 0);
    chk("eof_ptr", int'(dut.rd_ptr), 3);
    play = 1'b0;
    repeat (3) tick();

    // Pause during byte 1.
    pulse_rewind();
    push(0, 0); push(1, T + 3);
    play = 1'b1;
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 400);
    wait_busy(1'b1, 20);
    repeat (10) tick();
    play = 1'b0;
    wait_busy(1'b0, 400);
    lows = 0;
    repeat (40) begin tick(); if (!tape_out || busy) lows++; end
    chk("pause_idle_lows", lows, 0);
    chk("pause_ptr", int'(dut.rd_ptr), 2);
    push(2, 0);
    play = 1'b1;
    wait_eof(400);
    play = 1'b0;
    repeat (3) tick();

    // Rewind while a byte is in flight.
    pulse_rewind();
    push(0, 0);
    play = 1'b1;
    wait_busy(1'b1, 20);
    play = 1'b0;
    repeat (20) tick();
    pulse_rewind();
    wait_busy(1'b0, 400);
    chk("rewind_busy_ptr", int'(dut.rd_ptr), 0);
    chk("rewind_busy_eof", int'(eof), 0);

    // Random images played end to end.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      dl_open(8'd1);
      for (int i = 0; i < n; i++) dl_write(i, 8'($urandom_range(0, 255)));
      dl_close();
      chk("rand_len", int'(tape_len), n);
      push_run(0, model_len);
      play = 1'b1;
      wait_eof(n * 200 + 50);
      chk("rand_eof_ptr", int'(dut.rd_ptr), n);
      play = 1'b0;
      repeat (3) tick();
    end

    // New download aborts a frame in its low half.
    pulse_rewind();
    play = 1'b1;
    wait_busy(1'b1, 20);
    wait_low(100);
    dl_open(8'd1);
    chk("abort_tape_out", int'(tape_out), 1);
    chk("abort_busy", int'(busy), 0);
    bhi = 0;
    repeat (20) begin tick(); if (busy || !tape_out) bhi++; end
    chk("abort_inhibit", bhi, 0);
    dl_write(0, 8'hA5); dl_write(1, 8'h3C);
    dl_close();
    push_run(0, 2);
    chk("abort_len", int'(tape_len), 2);
    wait_eof(600);
    play = 1'b0;
    repeat (3) tick();

    // Capacity: 20 bytes into a 16-byte buffer.
    dl_open(8'd1);
    for (int i = 0; i < 20; i++) dl_write(i, 8'($urandom_range(0, 255)));
    dl_close();
    chk("cap_len", int'(tape_len), 16);
    push_run(0, 16);
    play = 1'b1;
    wait_eof(16 * 200);
    chk("cap_ptr", int'(dut.rd_ptr), 16);
    play = 1'b0;
    repeat (3) tick();

    // Reset in the low half of a cell.
    pulse_rewind();
    play = 1'b1;
    wait_busy(1'b1, 20);
    wait_low(100);
    reset = 1'b1;
    tick();
    chk("rst_lo_tape_out", int'(tape_out), 1);
    chk("rst_lo_busy", int'(busy), 0);
    chk("rst_lo_eof", int'(eof), 1);
    chk("rst_lo_len", int'(tape_len), 0);
    reset = 1'b0;
    play = 1'b0;
    repeat (10) tick();

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tap_player.md
# tap_player

Tape playback stage between the HPS file-download channel and the Oric core's cassette input.
- Captures a `.TAP` image delivered over the ioctl stream into an internal byte buffer.
- On command, replays the buffer as the Oric cassette waveform on `tape_out`, which drives the core's `K7_TAPEIN`.
- Upstream: `hps_io` ioctl outputs. Downstream: the Oric core tape input.
- The core sees a continuous serial bit stream exactly as a real cassette deck would produce it.

## Interface
Parameters:
- `ADDR_W`, 16, buffer address width; capacity is 2^ADDR_W bytes.
- `T_CYCLES`, 4992, clocks per tape half-period T (208 µs at 24 MHz); minimum 2.
- `TAP_INDEX`, 8'd1, ioctl_index value that selects the tape image.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ioctl_download` in 1: download window active.
- `ioctl_index` in 8: download target selector.
- `ioctl_wr` in 1: byte strobe, one cycle per byte.
- `ioctl_addr` in 25: byte address within the file.
- `ioctl_dout` in 8: byte data.
- `play` in 1: level; 1 = run, 0 = pause.
- `rewind` in 1: one-cycle pulse; returns the read pointer to 0.
- `tape_out` in/out: out 1; cassette signal, idles high.
- `busy` out 1: a byte is being serialised.
- `eof` out 1: read pointer == length and not busy.
- `tape_len` out ADDR_W+1: captured image length in bytes.

## Operation
- Capture runs when `ioctl_download && ioctl_index==TAP_INDEX`.
  - Each `ioctl_wr` writes `ioctl_dout` to `buf[ioctl_addr[ADDR_W-1:0]]`, only if `ioctl_addr < 2^ADDR_W`.
  - Bytes beyond capacity are dropped.
  - A running maximum tracks `min(ioctl_addr+1, 2^ADDR_W)`.
- End of capture: on the falling edge of the qualified download window, `tape_len` takes the running maximum, `rd_ptr` goes to 0 and the maximum clears.
- Abort: a qualified download starting mid-playback aborts playback immediately.
  - FSM goes to IDLE and `tape_out` goes to 1.
  - Playback stays inhibited while the download window is open.
- Byte frame, 14 bits, sent in this order:
  - start bit 0;
  - data bits D0..D7, LSB first;
  - odd parity bit P = ~^D, so the count of ones in D plus P is odd;
  - 4 stop bits of 1.
- Bit cell: `tape_out` high for T, then low for T (bit 1) or low for 2T (bit 0).
- FSM states:
  - IDLE: if `play && rd_ptr<tape_len && !downloading`, go to FETCH.
  - FETCH: BRAM read at `rd_ptr`, 1-cycle latency; go to LATCH.
  - LATCH: load the 14-bit shift register, set `bit_idx=0`, go to HI.
  - HI: `tape_out=1` for T_CYCLES, then go to LO.
  - LO: `tape_out=0` for T_CYCLES (bit 1) or 2·T_CYCLES (bit 0).
    - If `bit_idx<13`: shift, increment `bit_idx`, go to HI.
    - Otherwise: increment `rd_ptr`, go to IDLE.
- Pause: `play` is sampled only in IDLE, so the current byte always completes; output then holds 1.
- Back-to-back bytes: while `play` stays high, consecutive bytes are separated by exactly 3 idle cycles (IDLE, FETCH, LATCH).
- Rewind:
  - in IDLE, `rd_ptr` goes to 0 next cycle;
  - while busy, it is honoured at byte end, and the `rd_ptr` increment is replaced by 0.
- Simultaneous events: a download falling edge and `rewind` in the same cycle both yield `rd_ptr=0`.
- Widths:
  - `rd_ptr` and `tape_len` are ADDR_W+1 bits, so a full buffer gives `tape_len=2^ADDR_W` without wrap.
  - The half-period counter is `$clog2(2*T_CYCLES)` bits wide.

## Timing
- Reset values: `tape_out=1`, `busy=0`, `eof=1`, `tape_len=0`; `rd_ptr=0`, FSM in IDLE.
- Buffer contents are not cleared by reset.
- Start latency: from `play` rising in IDLE to `tape_out` rising at the start of the HI phase is 3 cycles.
  - During those cycles `tape_out` is already 1, so the first visible edge is the fall at HI+T.
- Per-byte duration: T·(2·ones(D) + 2·[P] + 8 + 3 + 3·zeros(D) + 3·[!P]) + 3 idle cycles.
  - Bit 1 costs 2T; bit 0 costs 3T.
- `busy` is high from FETCH through the last LO cycle inclusive.
- `eof` is combinational from the registered pointer, length and FSM state.
- A write is visible to a FETCH issued the cycle after it.

## Test plan
- Reset with `T_CYCLES=4`: all outputs hold their reset values; `tape_out` stays 1 for 100 cycles with `play=1` and `tape_len=0`.
- Download 3 bytes 0x16,0x16,0x24 at addr 0..2, index 1:
  - `tape_len=3` after the falling edge;
  - a second download with index 2 leaves `tape_len` unchanged.
- Play 0x16 with T=4:
  - the waveform decodes to start 0, data LSB first 0,1,1,0,1,0,0,0, P=0, then 1,1,1,1;
  - byte length is 4·(6+0+8+3+15+3) = 140 cycles;
  - cycle count from the first HI to the return to IDLE is checked.
- Play all three bytes:
  - gaps of exactly 3 cycles between frames;
  - `eof` rises the cycle after the final LO ends, with `rd_ptr=3`.
- Deassert `play` mid-byte 1: byte 1 completes, `tape_out` holds 1, `rd_ptr=2`; reassert `play` and byte 2 (0x24) follows.
- Boundary cases:
  - `rewind` mid-byte gives `rd_ptr=0` at byte end;
  - a new download mid-byte forces `tape_out=1` within 1 cycle;
  - `ADDR_W=4` with 20 bytes written gives `tape_len=16`;
  - `reset` mid-LO gives `tape_out=1` next cycle.
